// File: rtl/i2c_initializer.sv
`timescale 1ns/1ps
// i2c_initializer
//   Camera bring-up sequencer. A trigger pulse walks a fixed table of
//   16-bit-address / 8-bit-data register writes and issues each one as a
//   single open-drain I2C write (START, dev addr + W, addr hi, addr lo, data,
//   STOP). A table-walking controller feeds a byte/bit transmitter over a
//   valid/ready handshake.
//
// Parameters
//   CLK_DIV      system clocks per SCL quarter period (bit = 4*CLK_DIV)
//   DEV_ADDR     7-bit slave address, always written with R/W = 0
//   NUM_ENTRIES  number of table entries walked per trigger
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   trigger_i    one-cycle start pulse, ignored while busy_o is high
//   sda_io       open-drain SDA (drives 0 or Z)
//   scl_io       open-drain SCL (drives 0 or Z)
//   busy_o       high from accepted trigger until the final STOP completes
//   done_o       one-cycle pulse when the sequence ends (success or abort)
//   ack_error_o  sticky NACK flag, cleared by the next accepted trigger
//
// Controller FSM
//   state      | meaning
//   C_IDLE     | waiting for trigger_i, bus released
//   C_LOAD     | current table entry presented to the transmitter (valid=1)
//   C_WAIT_TX  | transaction in flight, waiting for transmitter ready
//   C_NEXT     | advance index, or finish on last entry / NACK (done_o)
//
// Transmitter FSM
//   state      | meaning
//   T_IDLE     | ready=1, both lines released
//   T_START    | SDA low with SCL released for 2Q
//   T_BYTE     | 8 data bits + ACK slot per byte, 4 bytes per transaction
//   T_STOP     | SDA low/SCL low Q, SCL release 2Q, SDA release 2Q
module i2c_initializer #(
    parameter int unsigned CLK_DIV     = 25,
    parameter logic [6:0]  DEV_ADDR    = 7'h3C,
    parameter int unsigned NUM_ENTRIES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger_i,
    inout  wire  sda_io,
    inout  wire  scl_io,
    output logic busy_o,
    output logic done_o,
    output logic ack_error_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [CNT_W-1:0] Q_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {C_IDLE, C_LOAD, C_WAIT_TX, C_NEXT} ctrl_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_BYTE, T_STOP} tx_state_t;

    ctrl_state_t       ctrl_state;
    ctrl_state_t       ctrl_next;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       tbl_addr;
    logic [7:0]        tbl_data;
    logic [31:0]       tx_word;
    logic              tx_valid;
    logic              tx_ready;

    tx_state_t         tx_state;
    tx_state_t         tx_next;
    logic              tx_accept;
    logic [CNT_W-1:0]  q_cnt;
    logic              q_tc;
    logic [2:0]        ph;
    logic              ph_last;
    logic [3:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [31:0]       shift_reg;
    logic              tx_nack;

    logic [1:0]        sda_sync;
    logic              sda_drv;
    logic              scl_drv;
    logic              sda_oe;
    logic              scl_oe;

    // ------------------------------------------------------------------
    // Register table
    // ------------------------------------------------------------------
    always_comb begin
        tbl_addr = 16'h0000;
        tbl_data = 8'h00;
        case (int'(idx))
            0: begin tbl_addr = 16'h3008; tbl_data = 8'h82; end
            1: begin tbl_addr = 16'h3103; tbl_data = 8'h03; end
            2: begin tbl_addr = 16'h3017; tbl_data = 8'hFF; end
            3: begin tbl_addr = 16'h3018; tbl_data = 8'hFF; end
            default: begin tbl_addr = 16'h0000; tbl_data = 8'h00; end
        endcase
    end

    assign tx_word = {DEV_ADDR, 1'b0, tbl_addr, tbl_data};

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_next = ctrl_state;
        tx_valid  = 1'b0;
        done_o    = 1'b0;
        case (ctrl_state)
            C_IDLE: begin
                if (trigger_i) ctrl_next = C_LOAD;
            end
            C_LOAD: begin
                tx_valid = 1'b1;
                if (tx_ready) ctrl_next = C_WAIT_TX;
            end
            C_WAIT_TX: begin
                if (tx_ready) ctrl_next = C_NEXT;
            end
            C_NEXT: begin
                if (tx_nack || idx == IDX_LAST) begin
                    ctrl_next = C_IDLE;
                    done_o    = 1'b1;
                end else begin
                    ctrl_next = C_LOAD;
                end
            end
            default: ctrl_next = C_IDLE;
        endcase
    end

    assign busy_o = (ctrl_state != C_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_state  <= C_IDLE;
            idx         <= '0;
            ack_error_o <= 1'b0;
        end else begin
            ctrl_state <= ctrl_next;
            if (ctrl_state == C_IDLE && trigger_i) begin
                idx         <= '0;
                ack_error_o <= 1'b0;
            end
            if (ctrl_state == C_NEXT) begin
                if (tx_nack) ack_error_o <= 1'b1;
                if (!tx_nack && idx != IDX_LAST) idx <= idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    assign tx_accept = (tx_state == T_IDLE) && tx_valid;
    assign q_tc      = (q_cnt == '0);

    always_comb begin
        tx_next  = tx_state;
        tx_ready = 1'b0;
        sda_drv  = 1'b0;
        scl_drv  = 1'b0;
        ph_last  = 1'b0;
        case (tx_state)
            T_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) tx_next = T_START;
            end
            T_START: begin
                sda_drv = 1'b1;
                ph_last = (ph == 3'd1);
                if (q_tc && ph_last) tx_next = T_BYTE;
            end
            T_BYTE: begin
                // SCL low in q0 and q3; ACK slot releases SDA for the slave
                scl_drv = (ph == 3'd0) || (ph == 3'd3);
                sda_drv = (bit_cnt == 4'd8) ? 1'b0 : ~shift_reg[31];
                ph_last = (ph == 3'd3);
                if (q_tc && ph_last && bit_cnt == 4'd8 && (tx_nack || byte_cnt == 2'd3))
                    tx_next = T_STOP;
            end
            T_STOP: begin
                sda_drv = (ph <= 3'd2);
                scl_drv = (ph == 3'd0);
                ph_last = (ph == 3'd4);
                if (q_tc && ph_last) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state  <= T_IDLE;
            q_cnt     <= Q_LOAD;
            ph        <= 3'd0;
            bit_cnt   <= 4'd0;
            byte_cnt  <= 2'd0;
            shift_reg <= 32'h0;
            tx_nack   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_accept) begin
                q_cnt     <= Q_LOAD;
                ph        <= 3'd0;
                bit_cnt   <= 4'd0;
                byte_cnt  <= 2'd0;
                shift_reg <= tx_word;
                tx_nack   <= 1'b0;
            end else if (tx_state != T_IDLE) begin
                if (!q_tc) begin
                    q_cnt <= q_cnt - 1'b1;
                end else begin
                    q_cnt <= Q_LOAD;
                    ph    <= ph_last ? 3'd0 : ph + 3'd1;
                    if (tx_state == T_BYTE) begin
                        // end of q1 is the middle of SCL-high for the ACK slot
                        if (ph == 3'd1 && bit_cnt == 4'd8) tx_nack <= sda_sync[1];
                        if (ph_last) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt  <= 4'd0;
                                byte_cnt <= byte_cnt + 2'd1;
                            end else begin
                                bit_cnt   <= bit_cnt + 4'd1;
                                shift_reg <= {shift_reg[30:0], 1'b0};
                            end
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pins: registered drive enables so the lines never glitch on decode,
    // and reset releases them without waiting for a clock.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
            sda_sync <= 2'b11;
        end else begin
            sda_oe   <= sda_drv;
            scl_oe   <= scl_drv;
            sda_sync <= {sda_sync[0], sda_io};
        end
    end

    assign sda_io = sda_oe ? 1'b0 : 1'bz;
    assign scl_io = scl_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_initializer.sv
`timescale 1ns/1ps
module tb_i2c_initializer;
    localparam int CLK_DIV = 25;
    localparam int Q       = CLK_DIV;

    logic clock         = 1'b0;
    logic reset         = 1'b1;
    logic trigger_i     = 1'b0;
    wire  sda_io;
    wire  scl_io;
    logic busy_o;
    logic done_o;
    logic ack_error_o;
    logic slave_sda_low = 1'b0;

    pullup (sda_io);
    pullup (scl_io);
    assign sda_io = slave_sda_low ? 1'b0 : 1'bz;

    i2c_initializer #(
        .CLK_DIV    (CLK_DIV),
        .DEV_ADDR   (7'h3C),
        .NUM_ENTRIES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .trigger_i  (trigger_i),
        .sda_io     (sda_io),
        .scl_io     (scl_io),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ack_error_o(ack_error_o)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int txn_cnt  = 0;
    int done_cnt = 0;
    int nack_txn  = -1;
    int nack_byte = -1;

    logic [7:0] exp_bytes[$];
    int         exp_len[$];

    logic [7:0] table_bytes [16] = '{8'h78, 8'h30, 8'h08, 8'h82,
                                     8'h78, 8'h31, 8'h03, 8'h03,
                                     8'h78, 8'h30, 8'h17, 8'hFF,
                                     8'h78, 8'h30, 8'h18, 8'hFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // expected bytes for one accepted trigger; stops after a NACKed byte
    task automatic push_seq(input int nack_entry, input int nack_at);
        for (int e = 0; e < 4; e++) begin
            for (int b = 0; b < 4; b++) begin
                exp_bytes.push_back(table_bytes[e*4 + b]);
                if (e == nack_entry && b == nack_at) begin
                    exp_len.push_back(b + 1);
                    return;
                end
            end
            exp_len.push_back(4);
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clock); trigger_i = 1'b1;
        @(negedge clock); trigger_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("done_within_budget", done_cnt != d0, 1);
    endtask

    // bus monitor, slave ACK model and bit-timing checker
    initial begin : monitor
        logic ps, pc, s, c, pdone, in_txn, high_valid, low_valid, first_low;
        logic [7:0] shreg;
        int bit_cnt, nbytes, high_len, low_len;
        ps = 1'b1; pc = 1'b1; pdone = 1'b0; in_txn = 1'b0;
        high_valid = 1'b0; low_valid = 1'b0; first_low = 1'b0;
        shreg = 8'h00; bit_cnt = 0; nbytes = 0; high_len = 0; low_len = 0;
        forever begin
            @(negedge clock);
            s = sda_io;
            c = scl_io;
            if (!reset) begin
                in_txn = 1'b0; bit_cnt = 0; high_valid = 1'b0; low_valid = 1'b0;
                slave_sda_low = 1'b0; pdone = 1'b0;
            end else begin
                if (done_o) begin
                    done_cnt++;
                    check("done_one_cycle", pdone, 0);
                end
                pdone = done_o;
                if (pc && c && ps && !s) begin
                    in_txn = 1'b1; bit_cnt = 0; nbytes = 0;
                    high_valid = 1'b0; low_valid = 1'b0; first_low = 1'b1;
                end else if (pc && c && !ps && s) begin
                    if (in_txn) begin
                        check("stop_after_ack_slot", bit_cnt, 1);
                        check("txn_expected", exp_len.size() != 0, 1);
                        if (exp_len.size() != 0) check("txn_bytes", nbytes, exp_len.pop_front());
                        txn_cnt++;
                    end
                    in_txn = 1'b0; high_valid = 1'b0; low_valid = 1'b0;
                end else if (in_txn && !pc && c) begin
                    if (low_valid) check("scl_low_clocks", low_len, first_low ? Q : 2*Q);
                    first_low = 1'b0;
                    bit_cnt++;
                    if (bit_cnt <= 8) shreg = {shreg[6:0], s};
                    high_valid = 1'b1;
                end else if (in_txn && pc && !c) begin
                    if (high_valid) check("scl_high_clocks", high_len, 2*Q);
                    high_valid = 1'b0;
                    low_valid  = 1'b1;
                    if (bit_cnt == 8) begin
                        check("byte_expected", exp_bytes.size() != 0, 1);
                        if (exp_bytes.size() != 0) check("byte_value", shreg, exp_bytes.pop_front());
                        slave_sda_low = !(txn_cnt == nack_txn && nbytes == nack_byte);
                        nbytes++;
                    end else if (bit_cnt == 9) begin
                        slave_sda_low = 1'b0;
                        bit_cnt = 0;
                    end
                end
                if (c != pc) begin
                    if (c) high_len = 1; else low_len = 1;
                end else begin
                    if (c) high_len++; else low_len++;
                end
            end
            ps = s;
            pc = c;
        end
    end

    initial begin : stimulus
        int lat, t0, d0;
        logic idle_ok;

        // reset held two cycles, then quiet bus
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle_ok = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (sda_io !== 1'b1 || scl_io !== 1'b1 || busy_o !== 1'b0) idle_ok = 1'b0;
        end
        check("reset_sda_released", sda_io, 1);
        check("reset_scl_released", scl_io, 1);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_ack_error", ack_error_o, 0);
        check("idle_bus_quiet", idle_ok, 1);

        // full sequence, slave ACKs everything
        t0 = txn_cnt; d0 = done_cnt;
        push_seq(-1, -1);
        pulse_trigger();
        lat = 1;
        while (sda_io === 1'b1 && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("trigger_to_start_le4", lat <= 4, 1);
        check("busy_after_trigger", busy_o, 1);
        wait_done(20000, d0);
        repeat (2) @(negedge clock);
        check("seq_txn_count", txn_cnt - t0, 4);
        check("seq_done_count", done_cnt - d0, 1);
        check("seq_ack_error", ack_error_o, 0);
        check("seq_busy_low", busy_o, 0);
        check("seq_bytes_left", exp_bytes.size(), 0);

        // NACK on the address-high byte of entry 1
        t0 = txn_cnt; d0 = done_cnt;
        nack_txn  = txn_cnt + 1;
        nack_byte = 1;
        push_seq(1, 1);
        pulse_trigger();
        wait_done(20000, d0);
        repeat (2) @(negedge clock);
        check("nack_ack_error", ack_error_o, 1);
        check("nack_txn_count", txn_cnt - t0, 2);
        check("nack_done_count", done_cnt - d0, 1);
        check("nack_busy_low", busy_o, 0);
        check("nack_bytes_left", exp_bytes.size(), 0);
        nack_txn  = -1;
        nack_byte = -1;

        // triggers every 6000 clocks; only the first is accepted
        t0 = txn_cnt; d0 = done_cnt;
        push_seq(-1, -1);
        pulse_trigger();
        repeat (10) @(negedge clock);
        check("ack_error_cleared", ack_error_o, 0);
        repeat (5988) @(negedge clock);
        check("busy_at_6000", busy_o, 1);
        pulse_trigger();
        repeat (5998) @(negedge clock);
        check("busy_at_12000", busy_o, 1);
        pulse_trigger();
        wait_done(20000, d0);
        repeat (2000) @(negedge clock);
        check("multi_txn_count", txn_cnt - t0, 4);
        check("multi_done_count", done_cnt - d0, 1);
        check("multi_busy_low", busy_o, 0);
        check("multi_bytes_left", exp_bytes.size(), 0);

        // reset in the middle of the first byte
        t0 = txn_cnt; d0 = done_cnt;
        pulse_trigger();
        repeat (300) @(negedge clock);
        lat = 0;
        while (scl_io !== 1'b0 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("scl_low_before_reset", scl_io, 0);
        #1 reset = 1'b0;
        #1;
        check("async_reset_sda", sda_io, 1);
        check("async_reset_scl", scl_io, 1);
        check("async_reset_busy", busy_o, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_stop", txn_cnt - t0, 0);

        t0 = txn_cnt; d0 = done_cnt;
        push_seq(-1, -1);
        pulse_trigger();
        wait_done(20000, d0);
        repeat (2) @(negedge clock);
        check("after_reset_txn_count", txn_cnt - t0, 4);
        check("after_reset_done_count", done_cnt - d0, 1);
        check("after_reset_ack_error", ack_error_o, 0);
        check("after_reset_bytes_left", exp_bytes.size(), 0);
        check("after_reset_len_left", exp_len.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
